rf_flush_ctrl: RTL and testbench

Register-file rename-tag flush controller. It tracks which architectural registers have received a rename tag (Q) since the last flush. On a ROB misprediction flush, it walks only those registers, driving one tag-clear per cycle into the register file's clear port while holding the dispatcher stalled. It sits between the ROB, the dispatcher and the register file, and is the only agent that bulk-resets Q tags outside of reset.

---
 rtl/rf_flush_ctrl.sv | 86 ++++++++
 tb/tb_rf_flush_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rf_flush_ctrl.sv
// Rename-tag flush controller: records which architectural registers have
// been given a rename tag since the last flush. On a ROB flush it walks only
// those registers in ascending order, clearing one Q tag per cycle while the
// dispatcher is stalled, then pulses done back to the ROB.
module rf_flush_ctrl #(
   parameter int REG_SIZE = 32,
   parameter int REG_LEN  = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ena_from_dsp,
   input  logic [REG_LEN-1:0] rd_from_dsp,
   input  logic               flush_from_rob,
   output logic               stall_to_dsp,
   output logic               clr_ena_to_rf,
   output logic [REG_LEN-1:0] clr_rd_to_rf,
   output logic               done_to_rob,
   output logic               busy
);

   typedef enum logic {IDLE, WALK} state_t;

   state_t              state, state_nxt;
   logic [REG_SIZE-1:0] dirty, dirty_nxt;
   logic [REG_SIZE-1:0] pending, pending_nxt;
   logic [REG_LEN-1:0]  low_idx;
   logic                pend_any;

   assign pend_any = |pending;

   // Lowest set bit of pending; bit 0 is never set, so 0 means "none".
   always_comb begin
      low_idx = '0;
      for (int i = REG_SIZE - 1; i >= 1; i--)
         if (pending[i]) low_idx = REG_LEN'(i);
   end

   // Outputs depend only on state/pending, except stall which must rise in
   // the flush cycle itself so the dispatcher cannot slip in an allocation.
   assign busy          = (state == WALK);
   assign clr_ena_to_rf = busy & pend_any;
   assign clr_rd_to_rf  = clr_ena_to_rf ? low_idx : '0;
   assign done_to_rob   = busy & ~pend_any;
   assign stall_to_dsp  = rst & (flush_from_rob | busy);

   // Next-state: track allocations in IDLE, snapshot on flush, drain in WALK.
   always_comb begin
      state_nxt   = state;
      dirty_nxt   = dirty;
      pending_nxt = pending;
      case (state)
         IDLE: begin
            if (flush_from_rob) begin
               // Same-cycle allocation is dropped: it is squashed by the flush.
               pending_nxt = dirty;
               dirty_nxt   = '0;
               state_nxt   = WALK;
            end else if (ena_from_dsp && (rd_from_dsp != '0)) begin
               dirty_nxt[rd_from_dsp] = 1'b1;
            end
         end
         WALK: begin
            // Further flushes and (illegal) allocations are ignored here.
            if (pend_any) pending_nxt[low_idx] = 1'b0;
            else          state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      dirty_nxt[0]   = 1'b0;
      pending_nxt[0] = 1'b0;
   end

   // State register; reset forgets tracked registers since the RF resets Q too.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         dirty   <= '0;
         pending <= '0;
      end else begin
         state   <= state_nxt;
         dirty   <= dirty_nxt;
         pending <= pending_nxt;
      end
   end

endmodule

// File: tb/tb_rf_flush_ctrl.sv
// Directed bench for rf_flush_ctrl: inputs driven and outputs sampled on the
// falling edge, expected clear sequences written out by hand.
module tb_rf_flush_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena_from_dsp;
   logic [4:0] rd_from_dsp;
   logic       flush_from_rob;
   logic       stall_to_dsp;
   logic       clr_ena_to_rf;
   logic [4:0] clr_rd_to_rf;
   logic       done_to_rob;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   rf_flush_ctrl #(.REG_SIZE(32), .REG_LEN(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .ena_from_dsp   (ena_from_dsp),
      .rd_from_dsp    (rd_from_dsp),
      .flush_from_rob (flush_from_rob),
      .stall_to_dsp   (stall_to_dsp),
      .clr_ena_to_rf  (clr_ena_to_rf),
      .clr_rd_to_rf   (clr_rd_to_rf),
      .done_to_rob    (done_to_rob),
      .busy           (busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One cycle: drive inputs on the falling edge, settle, then caller checks.
   task automatic cyc(input logic e, input logic [4:0] rd, input logic fl);
      @(negedge clk);
      ena_from_dsp   = e;
      rd_from_dsp    = rd;
      flush_from_rob = fl;
      #1;
   endtask

   task automatic alloc(input logic [4:0] rd);
      cyc(1'b1, rd, 1'b0);
      chk("alloc_stall", stall_to_dsp, 0);
   endtask

   // Flush cycle, then expect exactly exp_q clears, one done, then IDLE.
   // refl re-pulses flush and sneaks in an allocation during the walk.
   task automatic run_flush(input logic fe, input logic [4:0] frd, input bit refl);
      int n;
      n = exp_q.size();
      cyc(fe, frd, 1'b1);
      chk("fl_stall", stall_to_dsp, 1);
      chk("fl_busy", busy, 0);
      chk("fl_clr", clr_ena_to_rf, 0);
      for (int k = 0; k < n; k++) begin
         cyc(refl && k == 1, 5'd20, refl && k == 0);
         chk("w_clr_ena", clr_ena_to_rf, 1);
         chk("w_clr_rd", clr_rd_to_rf, exp_q[k]);
         chk("w_stall", stall_to_dsp, 1);
         chk("w_done", done_to_rob, 0);
      end
      cyc(1'b0, 5'd0, 1'b0);
      chk("d_done", done_to_rob, 1);
      chk("d_clr", clr_ena_to_rf, 0);
      chk("d_rd", clr_rd_to_rf, 0);
      chk("d_stall", stall_to_dsp, 1);
      cyc(1'b0, 5'd0, 1'b0);
      chk("i_done", done_to_rob, 0);
      chk("i_stall", stall_to_dsp, 0);
      chk("i_busy", busy, 0);
   endtask

   initial begin
      rst = 1'b0; ena_from_dsp = 1'b1; rd_from_dsp = 5'd3; flush_from_rob = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", stall_to_dsp, 0);
      chk("rst_clr", clr_ena_to_rf, 0);
      chk("rst_rd", clr_rd_to_rf, 0);
      chk("rst_done", done_to_rob, 0);
      chk("rst_busy", busy, 0);
      cyc(1'b0, 5'd0, 1'b0);
      rst = 1'b1;

      // Flush with nothing tracked.
      exp_q = {};
      run_flush(1'b0, 5'd0, 1'b0);

      // Duplicate and r0 allocations.
      alloc(5); alloc(3); alloc(5); alloc(0);
      exp_q = {3, 5};
      run_flush(1'b0, 5'd0, 1'b0);

      // Every register, then an empty follow-up flush.
      exp_q = {};
      for (int r = 1; r < 32; r++) begin
         alloc(5'(r));
         exp_q.push_back(r);
      end
      run_flush(1'b0, 5'd0, 1'b0);
      exp_q = {};
      run_flush(1'b0, 5'd0, 1'b0);

      // Allocation in the flush cycle is discarded.
      alloc(2);
      exp_q = {2};
      run_flush(1'b1, 5'd7, 1'b0);
      exp_q = {};
      run_flush(1'b0, 5'd0, 1'b0);

      // Reset mid-walk.
      alloc(4); alloc(9); alloc(12);
      cyc(1'b0, 5'd0, 1'b1);
      cyc(1'b0, 5'd0, 1'b0);
      chk("r_clr4", clr_rd_to_rf, 4);
      cyc(1'b0, 5'd0, 1'b0);
      chk("r_clr9", clr_rd_to_rf, 9);
      rst = 1'b0;
      #1;
      chk("r_stall", stall_to_dsp, 0);
      chk("r_clr_ena", clr_ena_to_rf, 0);
      chk("r_clr_rd", clr_rd_to_rf, 0);
      chk("r_done", done_to_rob, 0);
      chk("r_busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      exp_q = {};
      run_flush(1'b0, 5'd0, 1'b0);

      // Re-flush and illegal allocation during the walk are ignored.
      alloc(6); alloc(8);
      exp_q = {6, 8};
      run_flush(1'b0, 5'd0, 1'b1);
      cyc(1'b0, 5'd0, 1'b0);
      chk("rf_no_done", done_to_rob, 0);
      chk("rf_no_busy", busy, 0);
      exp_q = {};
      run_flush(1'b0, 5'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
